// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs the req/ack handshake with instruction
// memory and presents one instruction at a time to decode. Handles hazard
// stalls, branch redirects (including redirects that arrive while a fetch is
// still outstanding) and the HLT instruction.
// Optional feature macro: FETCH_CNT_EN adds the fetch_cnt consumed-instruction
// counter port and its saturating counter.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic        halted
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0] fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        pendValid_q, pendValid_d;
    logic [15:0] pendTarget_q, pendTarget_d;

    // State, PC, presented instruction and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= 16'h0000;
            pendValid_q  <= 1'b0;
            pendTarget_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pendValid_q  <= pendValid_d;
            pendTarget_q <= pendTarget_d;
        end
    end

    // Next-state logic: the PC only moves on an ack (redirect) or when the
    // presented instruction is consumed or flushed, so imem_addr never changes
    // under an outstanding request.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pendValid_d  = pendValid_q;
        pendTarget_d = pendTarget_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        pc_d        = branch_target;
                        pendValid_d = 1'b0;
                    end else if (pendValid_q) begin
                        pc_d        = pendTarget_q;
                        pendValid_d = 1'b0;
                    end else begin
                        instr_d = imem_data;
                        state_d = ISSUE;
                    end
                end else if (branch_taken) begin
                    pendValid_d  = 1'b1;
                    pendTarget_d = branch_target;
                end
            end
            ISSUE: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = FETCH;
                end else if (stall) begin
                    state_d = ISSUE;
                end else if (halt) begin
                    state_d = HALTED;
                end else begin
                    pc_d    = pc_q + PC_INC;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // The request is masked by rst_n so memory sees it drop as soon as reset asserts.
    assign imem_req    = (state_q == FETCH) && rst_n;
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALTED);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;

`ifdef FETCH_CNT_EN
    logic [15:0] fetchCnt_q, fetchCnt_d;
    logic        consumed;

    assign consumed = (state_q == ISSUE) && !branch_taken && !stall;

    // Saturating count of consumed instructions, HLT included.
    always_comb begin
        fetchCnt_d = fetchCnt_q;
        if (consumed && (fetchCnt_q != 16'hFFFF)) begin
            fetchCnt_d = fetchCnt_q + 16'd1;
        end
    end

    // Consumed-instruction counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchCnt_q <= 16'h0000;
        end else begin
            fetchCnt_q <= fetchCnt_d;
        end
    end

    assign fetch_cnt = fetchCnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: a behavioural instruction memory with a
// programmable number of wait cycles answers with 16'hA000 + address; every
// word the bench expects decode to see is queued when memory acks and is
// compared when instr_valid rises. A second instance with RESET_PC=16'hFFFE
// and an always-acking memory covers the reset-value parameter.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        halt = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        halted;

    logic        zero1 = 1'b0;
    logic        one1 = 1'b1;
    logic [15:0] zero16 = 16'h0000;
    logic        req2;
    logic [15:0] addr2;
    logic [15:0] instr2;
    logic        valid2;
    logic [15:0] pc2;
    logic        halted2;

`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] fetch_cnt2;
`endif

    int          checks = 0;
    int          fails = 0;
    int          memWait = 0;
    int          waitCnt = 0;
    bit          sbEnable = 1'b1;
    bit          newValid = 1'b0;
    bit          prevValid = 1'b0;
    logic [15:0] sbQ[$];
    logic [15:0] expInstr;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .halted(halted)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt)
`endif
    );

    fetch_sequencer #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(zero1), .branch_taken(zero1),
        .branch_target(zero16), .halt(zero1), .imem_req(req2),
        .imem_addr(addr2), .imem_ack(one1), .imem_data(zero16),
        .instr(instr2), .instr_valid(valid2), .pc(pc2), .halted(halted2)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt2)
`endif
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Memory model: ack after memWait non-ack request cycles, queue the expected word.
    task automatic memRespond();
        if (imem_req) begin
            if (waitCnt == memWait) begin
                imem_ack  = 1'b1;
                imem_data = 16'hA000 + imem_addr;
                waitCnt   = 0;
                if (sbEnable) sbQ.push_back(16'hA000 + imem_addr);
            end else begin
                imem_ack  = 1'b0;
                imem_data = 16'hDEAD;
                waitCnt++;
            end
        end else begin
            imem_ack  = 1'b0;
            imem_data = 16'hDEAD;
            waitCnt   = 0;
        end
    endtask

    // One clock: outputs settle 1 ns after the edge, then memory answers.
    task automatic stepClock();
        @(posedge clk);
        #1;
        newValid  = instr_valid && !prevValid;
        prevValid = instr_valid;
        memRespond();
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        waitCnt   = 0;
        prevValid = 1'b0;
        newValid  = 1'b0;
        sbQ.delete();
        memRespond();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want 0000", pc); end
        checks++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        checks++; if (instr !== 16'h0000) begin fails++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (pc2 !== 16'hFFFE) begin fails++; $display("FAIL reset_pc_param: got %h want fffe", pc2); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_cnt !== 16'h0000) begin fails++; $display("FAIL reset_cnt: got %h want 0000", fetch_cnt); end
`endif
    endtask

    task automatic test_zero_wait();
        logic [15:0] expAddr;
        memWait  = 0;
        sbEnable = 1'b1;
        releaseReset();
        expAddr = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (instr_valid !== ((i % 2) == 1)) begin
                fails++; $display("FAIL zw_valid_pattern cycle %0d: got %b want %b", i, instr_valid, ((i % 2) == 1));
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== expAddr) begin fails++; $display("FAIL zw_addr: got %h want %h", imem_addr, expAddr); end
                expAddr = expAddr + 16'd2;
            end
            if (newValid) begin
                checks++;
                if (sbQ.size() == 0) begin fails++; $display("FAIL zw_sb: unexpected instr %h", instr); end
                else begin
                    expInstr = sbQ.pop_front();
                    if (instr !== expInstr) begin fails++; $display("FAIL zw_sb: got %h want %h", instr, expInstr); end
                end
            end
            stepClock();
        end
    endtask

    task automatic test_wait_latency();
        stepClock();
        if (newValid) begin
            checks++;
            if (sbQ.size() == 0) begin fails++; $display("FAIL wl_sb0: unexpected instr %h", instr); end
            else begin
                expInstr = sbQ.pop_front();
                if (instr !== expInstr) begin fails++; $display("FAIL wl_sb0: got %h want %h", instr, expInstr); end
            end
        end
        memWait = 2;
        stepClock();
        for (int k = 0; k < 3; k++) begin
            checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL wl_req k=%0d: got %b want 1", k, imem_req); end
            checks++; if (imem_addr !== 16'h000A) begin fails++; $display("FAIL wl_addr k=%0d: got %h want 000a", k, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL wl_valid_early k=%0d: got %b want 0", k, instr_valid); end
            checks++; if (imem_ack !== (k == 2)) begin fails++; $display("FAIL wl_ack_model k=%0d: got %b", k, imem_ack); end
            stepClock();
        end
        checks++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL wl_valid_after_ack: got %b want 1", instr_valid); end
        checks++;
        if (!newValid || sbQ.size() == 0) begin fails++; $display("FAIL wl_sb: no instr presented, valid=%b", instr_valid); end
        else begin
            expInstr = sbQ.pop_front();
            if (instr !== expInstr) begin fails++; $display("FAIL wl_sb: got %h want %h", instr, expInstr); end
        end
    endtask

    task automatic test_stall();
        memWait = 0;
        for (int k = 0; k < 6; k++) begin
            stepClock();
            if (newValid) begin
                checks++;
                if (sbQ.size() == 0) begin fails++; $display("FAIL st_sb: unexpected instr %h", instr); end
                else begin
                    expInstr = sbQ.pop_front();
                    if (instr !== expInstr) begin fails++; $display("FAIL st_sb: got %h want %h", instr, expInstr); end
                end
            end
        end
        checks++; if (pc !== 16'h0010 || instr_valid !== 1'b1) begin fails++; $display("FAIL st_reach: pc=%h valid=%b want 0010/1", pc, instr_valid); end
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            stepClock();
            if (k == 3) stall = 1'b0;
            checks++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL st_valid k=%0d: got %b want 1", k, instr_valid); end
            checks++; if (pc !== 16'h0010) begin fails++; $display("FAIL st_pc k=%0d: got %h want 0010", k, pc); end
            checks++; if (instr !== 16'hA010) begin fails++; $display("FAIL st_instr k=%0d: got %h want a010", k, instr); end
            checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL st_req k=%0d: got %b want 0", k, imem_req); end
        end
        stepClock();
        checks++; if (pc !== 16'h0012) begin fails++; $display("FAIL st_advance_pc: got %h want 0012", pc); end
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL st_advance_req: got %b want 1", imem_req); end
    endtask

    task automatic test_branch();
        memWait = 3;
        stepClock();
        checks++;
        if (!newValid || sbQ.size() == 0) begin fails++; $display("FAIL br_sb0: no instr presented, valid=%b", instr_valid); end
        else begin
            expInstr = sbQ.pop_front();
            if (instr !== expInstr) begin fails++; $display("FAIL br_sb0: got %h want %h", instr, expInstr); end
        end
        sbEnable = 1'b0;
        stepClock();
        branch_taken = 1'b1; branch_target = 16'h0100;
        stepClock();
        checks++; if (imem_addr !== 16'h0014) begin fails++; $display("FAIL br_addr_hold1: got %h want 0014", imem_addr); end
        branch_target = 16'h0200;
        stepClock();
        branch_taken = 1'b0; branch_target = 16'h0000;
        checks++; if (imem_addr !== 16'h0014) begin fails++; $display("FAIL br_addr_hold2: got %h want 0014", imem_addr); end
        stepClock();
        checks++; if (imem_ack !== 1'b1 || imem_addr !== 16'h0014) begin fails++; $display("FAIL br_ack_cycle: ack=%b addr=%h want 1/0014", imem_ack, imem_addr); end
        sbEnable = 1'b1;
        stepClock();
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_addr !== 16'h0200) begin fails++; $display("FAIL br_redirect_addr k=%0d: got %h want 0200", k, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL br_stale_valid k=%0d: got %b want 0", k, instr_valid); end
            stepClock();
        end
        checks++;
        if (!newValid || sbQ.size() == 0) begin fails++; $display("FAIL br_sb: no instr presented, valid=%b", instr_valid); end
        else begin
            expInstr = sbQ.pop_front();
            if (instr !== expInstr) begin fails++; $display("FAIL br_sb: got %h want %h", instr, expInstr); end
        end
        memWait = 0;
        sbEnable = 1'b0;
        branch_taken = 1'b1; branch_target = 16'h0040;
        stepClock();
        checks++; if (pc !== 16'h0040 || instr_valid !== 1'b0) begin fails++; $display("FAIL br_issue_flush: pc=%h valid=%b want 0040/0", pc, instr_valid); end
        sbEnable = 1'b1;
        stepClock();
        branch_taken = 1'b0; branch_target = 16'h0000;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== 16'h0040) begin fails++; $display("FAIL br_ack_concurrent: valid=%b req=%b pc=%h want 0/1/0040", instr_valid, imem_req, pc); end
        stepClock();
        checks++;
        if (!newValid || sbQ.size() == 0) begin fails++; $display("FAIL br_sb2: no instr presented, valid=%b", instr_valid); end
        else begin
            expInstr = sbQ.pop_front();
            if (instr !== expInstr) begin fails++; $display("FAIL br_sb2: got %h want %h", instr, expInstr); end
        end
    endtask

    task automatic test_halt();
        halt = 1'b1; stall = 1'b1;
        stepClock();
        checks++; if (halted !== 1'b0 || instr_valid !== 1'b1) begin fails++; $display("FAIL ht_stall_hold: halted=%b valid=%b want 0/1", halted, instr_valid); end
        stall = 1'b0;
        stepClock();
        halt = 1'b0;
        checks++; if (halted !== 1'b1) begin fails++; $display("FAIL ht_enter: got %b want 1", halted); end
        checks++; if (pc !== 16'h0040) begin fails++; $display("FAIL ht_pc: got %h want 0040", pc); end
        for (int k = 0; k < 5; k++) begin
            branch_taken = 1'b1; branch_target = 16'h1234; stall = k[0]; halt = 1'b1;
            stepClock();
            imem_ack = 1'b1; imem_data = 16'h5555;
            checks++; if (halted !== 1'b1 || pc !== 16'h0040) begin fails++; $display("FAIL ht_frozen k=%0d: halted=%b pc=%h want 1/0040", k, halted, pc); end
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL ht_outputs k=%0d: req=%b valid=%b want 0/0", k, imem_req, instr_valid); end
        end
        branch_taken = 1'b0; branch_target = 16'h0000; stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0000) begin fails++; $display("FAIL ht_reset_exit: halted=%b req=%b pc=%h want 0/0/0000", halted, imem_req, pc); end
    endtask

    task automatic test_wrap();
        memWait = 0;
        sbEnable = 1'b1;
        releaseReset();
        checks++; if (req2 !== 1'b1 || addr2 !== 16'hFFFE) begin fails++; $display("FAIL wr_param_first: req=%b addr=%h want 1/fffe", req2, addr2); end
        stepClock();
        checks++;
        if (!newValid || sbQ.size() == 0) begin fails++; $display("FAIL wr_sb0: no instr presented, valid=%b", instr_valid); end
        else begin
            expInstr = sbQ.pop_front();
            if (instr !== expInstr) begin fails++; $display("FAIL wr_sb0: got %h want %h", instr, expInstr); end
        end
        checks++; if (valid2 !== 1'b1 || instr2 !== 16'h0000) begin fails++; $display("FAIL wr_param_issue: valid=%b instr=%h want 1/0000", valid2, instr2); end
        branch_taken = 1'b1; branch_target = 16'hFFFE;
        stepClock();
        branch_taken = 1'b0; branch_target = 16'h0000;
        checks++; if (req2 !== 1'b1 || addr2 !== 16'h0000 || halted2 !== 1'b0) begin fails++; $display("FAIL wr_param_second: req=%b addr=%h halted=%b want 1/0000/0", req2, addr2, halted2); end
`ifdef FETCH_CNT_EN
        checks++; if (fetch_cnt2 !== 16'h0001) begin fails++; $display("FAIL wr_param_cnt: got %h want 0001", fetch_cnt2); end
`endif
        checks++; if (imem_addr !== 16'hFFFE) begin fails++; $display("FAIL wr_branch_addr: got %h want fffe", imem_addr); end
        stepClock();
        checks++;
        if (!newValid || sbQ.size() == 0) begin fails++; $display("FAIL wr_sb1: no instr presented, valid=%b", instr_valid); end
        else begin
            expInstr = sbQ.pop_front();
            if (instr !== expInstr) begin fails++; $display("FAIL wr_sb1: got %h want %h", instr, expInstr); end
        end
        stepClock();
        checks++; if (pc !== 16'h0000 || imem_req !== 1'b1) begin fails++; $display("FAIL wr_wrap: pc=%h req=%b want 0000/1", pc, imem_req); end
    endtask

`ifdef FETCH_CNT_EN
    task automatic test_count();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (fetch_cnt !== 16'h0000) begin fails++; $display("FAIL cnt_reset: got %h want 0000", fetch_cnt); end
        memWait = 0;
        releaseReset();
        stepClock();
        stepClock();
        stepClock();
        stall = 1'b1;
        stepClock();
        stall = 1'b0;
        checks++; if (fetch_cnt !== 16'h0001) begin fails++; $display("FAIL cnt_stall: got %h want 0001", fetch_cnt); end
        stepClock();
        stepClock();
        stepClock();
        stepClock();
        halt = 1'b1;
        stepClock();
        halt = 1'b0;
        checks++; if (halted !== 1'b1 || fetch_cnt !== 16'h0004) begin fails++; $display("FAIL cnt_after_hlt: halted=%b cnt=%h want 1/0004", halted, fetch_cnt); end
        stepClock();
        stepClock();
        checks++; if (fetch_cnt !== 16'h0004) begin fails++; $display("FAIL cnt_hold: got %h want 0004", fetch_cnt); end
    endtask
`endif

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_zero_wait();
        test_wait_latency();
        test_stall();
        test_branch();
        test_halt();
        test_wrap();
`ifdef FETCH_CNT_EN
        test_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
